// File: rtl/wb_common_pkg.sv
// Shared Wishbone definitions: sequencer FSM encoding, classic-cycle tie-offs and
// big-endian byte-lane helpers.
package wb_common_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Byte offset 0 is the most significant byte of the word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (off)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_sel_lane_enc.sv
// Pending-lane mask to byte offset of the highest set bit (sel[3] -> offset 0),
// plus a flag when no lane is left.
module wb_sel_lane_enc
  import wb_common_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] lane,
  output logic       none
);

  always_comb begin
    lane = 2'd3;
    if (mask[3])      lane = 2'd0;
    else if (mask[2]) lane = 2'd1;
    else if (mask[1]) lane = 2'd2;
    none = (mask == 4'b0000);
  end

endmodule

// File: rtl/wb_resize_sequencer.sv
// Splits one 32-bit Wishbone access into up to four classic 8-bit slave accesses.
// Optional slave-ack watchdog enabled by defining WB_RESIZE_TIMEOUT_EN.
module wb_resize_sequencer
  import wb_common_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] wbm_adr_i,
  input  logic [31:0]   wbm_dat_i,
  input  logic [3:0]    wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  output logic [31:0]   wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_err_o,
  output logic          wbm_rty_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [7:0]    wbs_dat_o,
  output logic          wbs_we_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  input  logic [7:0]    wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i
);

  wb_state_e       state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [AW-3:0]   adr_q, adr_d;
  logic            we_q, we_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     buf_q, buf_d;
  logic            cyc_q, cyc_d;
  logic            ack_d, err_d, rty_d;
  logic [1:0]      nxt_lane;
  logic            nxt_none;
  logic            req, tmo_hit, slv_fail;
  logic [3:0]      cur_bit;
  logic            unused_adr_lsb;

  assign req            = wbm_cyc_i & wbm_stb_i;
  assign cur_bit        = 4'b1000 >> wbs_adr_o[1:0];
  assign slv_fail       = wbs_err_i | wbs_rty_i | tmo_hit;
  assign unused_adr_lsb = ^wbm_adr_i[1:0];

  assign wbs_cyc_o = cyc_q & wbm_cyc_i;
  assign wbs_stb_o = cyc_q & wbm_cyc_i;
  assign wbs_cti_o = CTI_CLASSIC;
  assign wbs_bte_o = BTE_LINEAR;

`ifdef WB_RESIZE_TIMEOUT_EN
  localparam int              CNT_W   = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Held at zero outside XFER so the count starts fresh on every entry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                              tmo_cnt_q <= '0;
    else if ((state_q != ST_XFER) || wbs_ack_i)  tmo_cnt_q <= '0;
    else                                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == ST_XFER) && (tmo_cnt_q == TMO_LIM);
`else
  // No watchdog: XFER waits for the slave indefinitely.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  // Kept separate from the FSM so the lane encoder sees the next mask without a comb loop.
  always_comb begin
    mask_d = mask_q;
    case (state_q)
      ST_IDLE: if (req) mask_d = wbm_sel_i;
      ST_XFER: begin
        if (!wbm_cyc_i || slv_fail) mask_d = 4'b0000;
        else if (wbs_ack_i)         mask_d = mask_q & ~cur_bit;
      end
      default: mask_d = 4'b0000;
    endcase
  end

  wb_sel_lane_enc u_lane_enc (
    .mask (mask_d),
    .lane (nxt_lane),
    .none (nxt_none)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    buf_d   = buf_q;
    cyc_d   = cyc_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d = wbm_adr_i[AW-1:2];
          we_d  = wbm_we_i;
          dat_d = wbm_dat_i;
          buf_d = '0;
          if (nxt_none) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_XFER;
            cyc_d   = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (!wbm_cyc_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
        end else if (slv_fail) begin
          state_d = ST_FAIL;
          cyc_d   = 1'b0;
          err_d   = wbs_err_i | tmo_hit;
          rty_d   = wbs_rty_i & ~wbs_err_i & ~tmo_hit;
        end else if (wbs_ack_i) begin
          buf_d = put_byte(buf_q, wbs_adr_o[1:0], wbs_dat_i);
          if (nxt_none) begin
            state_d = ST_DONE;
            cyc_d   = 1'b0;
            ack_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // Terminations and slave address/data are registered from the next-state values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      buf_q     <= '0;
      cyc_q     <= 1'b0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_we_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      buf_q     <= buf_d;
      cyc_q     <= cyc_d;
      wbm_dat_o <= ack_d ? buf_d : 32'h0;
      wbm_ack_o <= ack_d;
      wbm_err_o <= err_d;
      wbm_rty_o <= rty_d;
      wbs_adr_o <= cyc_d ? {adr_d, nxt_lane} : '0;
      wbs_dat_o <= cyc_d ? get_byte(dat_d, nxt_lane) : 8'h00;
      wbs_we_o  <= cyc_d & we_d;
    end
  end

endmodule

// File: tb/tb_wb_resize_sequencer.sv
// Self-checking bench for wb_resize_sequencer: scripted 8-bit slave, transaction-level
// reference model, directed scenarios and a randomized sweep.
module tb_wb_resize_sequencer;

  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni;
  logic [AW-1:0] wbm_adr_i;
  logic [31:0]   wbm_dat_i;
  logic [3:0]    wbm_sel_i;
  logic          wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [31:0]   wbm_dat_o;
  logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0] wbs_adr_o;
  logic [7:0]    wbs_dat_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [7:0]    wbs_dat_i;
  logic          wbs_ack_i, wbs_err_i, wbs_rty_i;

  wb_resize_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // Slave script per access: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err, 5 err+rty.
  int         scr_kind [4];
  int         scr_wait [4];
  logic [7:0] scr_data [4];

  // Append-only logs written by the slave/monitor process.
  logic [AW-1:0] acc_adr [$];
  logic [7:0]    acc_dat [$];
  logic          acc_we  [$];
  int            term_kind [$];
  int            term_cyc  [$];
  logic [31:0]   term_dat  [$];
  int            cyc_hi = 0;
  int            s_idx  = 0;
  int            s_wcnt = 0;

  always @(negedge wb_clk_i) begin
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;
    wbs_dat_i = 8'h00;
    if (wbm_ack_o) begin term_kind.push_back(0); term_cyc.push_back(cyc_n); term_dat.push_back(wbm_dat_o); end
    if (wbm_err_o) begin term_kind.push_back(1); term_cyc.push_back(cyc_n); term_dat.push_back(wbm_dat_o); end
    if (wbm_rty_o) begin term_kind.push_back(2); term_cyc.push_back(cyc_n); term_dat.push_back(wbm_dat_o); end
    if (wbs_cyc_o) cyc_hi++;
    if (wbs_cyc_o && wbs_stb_o) begin
      if (scr_kind[s_idx] != 3 && s_wcnt >= scr_wait[s_idx]) begin
        acc_adr.push_back(wbs_adr_o);
        acc_dat.push_back(wbs_dat_o);
        acc_we.push_back(wbs_we_o);
        wbs_dat_i = scr_data[s_idx];
        wbs_ack_i = (scr_kind[s_idx] == 0) || (scr_kind[s_idx] == 4);
        wbs_err_i = (scr_kind[s_idx] == 1) || (scr_kind[s_idx] == 4) || (scr_kind[s_idx] == 5);
        wbs_rty_i = (scr_kind[s_idx] == 2) || (scr_kind[s_idx] == 5);
        if (s_idx < 3) s_idx++;
        s_wcnt = 0;
      end else begin
        s_wcnt++;
      end
    end else begin
      s_wcnt = 0;
      if (!wbs_cyc_o) s_idx = 0;
    end
  end

  // Reference model: expected accesses, termination, read word and latency.
  logic [AW-1:0] exp_adr [4];
  logic [7:0]    exp_wdat [4];
  int            exp_kind, exp_lat, exp_n;
  logic [31:0]   exp_rd;

  task automatic model_xfer(input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit stop;
    stop     = 1'b0;
    exp_kind = 0;
    exp_rd   = 32'h0;
    exp_lat  = 1;
    exp_n    = 0;
    for (int o = 0; o < 4; o++) begin
      if (sel[3-o] && !stop) begin
        exp_adr[exp_n]  = {adr[AW-1:2], 2'(o)};
        exp_wdat[exp_n] = dat[31-8*o -: 8];
        exp_lat += scr_wait[exp_n] + 1;
        if (scr_kind[exp_n] == 0) begin
          exp_rd[31-8*o -: 8] = scr_data[exp_n];
        end else begin
          exp_kind = (scr_kind[exp_n] == 2) ? 2 : 1;
          stop     = 1'b1;
        end
        exp_n++;
      end
    end
  endtask

  task automatic set_script(input int k0, input int k1, input int k2, input int k3, input int w);
    scr_kind[0] = k0; scr_kind[1] = k1; scr_kind[2] = k2; scr_kind[3] = k3;
    for (int k = 0; k < 4; k++) scr_wait[k] = w;
  endtask

  // Drives one master request and holds it until a termination appears (bounded).
  task automatic do_xfer(input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output int c0, output int tb, output int ab, output bit to);
    @(posedge wb_clk_i); #1;
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    c0 = cyc_n;
    tb = term_kind.size();
    ab = acc_adr.size();
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i); #1;
      if (term_kind.size() > tb) begin to = 1'b0; break; end
    end
    @(posedge wb_clk_i); #1;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    set_script(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) scr_data[k] = 8'h00;
    #2;
    checks++;
    if ({wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 35'h0) begin
      errors++; $display("FAIL reset_master_outs: got %h want 0", {wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o});
    end
    checks++;
    if ({wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_cyc_o, wbs_stb_o} !== 43'h0) begin
      errors++; $display("FAIL reset_slave_outs: got %h want 0", {wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_cyc_o, wbs_stb_o});
    end
    repeat (3) @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    checks++;
    if ({wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbm_ack_o} !== 7'h0) begin
      errors++; $display("FAIL idle_ties: got %h want 0", {wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbm_ack_o});
    end
  endtask

  task automatic test_write_full();
    int c0, tb, ab; bit to;
    logic [AW-1:0] want_a [4];
    logic [7:0]    want_d [4];
    want_a = '{32'h100, 32'h101, 32'h102, 32'h103};
    want_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    set_script(0, 0, 0, 0, 0);
    do_xfer(32'h100, 32'hAABBCCDD, 4'b1111, 1'b1, c0, tb, ab, to);
    checks++;
    if (to || term_kind.size() - tb != 1 || term_kind[tb] != 0) begin
      errors++; $display("FAIL wr_term: got %0d terms timeout=%0d want one ack", term_kind.size() - tb, to);
    end else begin
      checks++;
      if (term_cyc[tb] - c0 != 5) begin errors++; $display("FAIL wr_latency: got %0d want 5", term_cyc[tb] - c0); end
    end
    checks++;
    if (acc_adr.size() - ab != 4) begin
      errors++; $display("FAIL wr_count: got %0d want 4", acc_adr.size() - ab);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (acc_adr[ab+k] !== want_a[k] || acc_dat[ab+k] !== want_d[k] || acc_we[ab+k] !== 1'b1) begin
          errors++; $display("FAIL wr_access[%0d]: got %h/%h we=%b want %h/%h we=1",
                             k, acc_adr[ab+k], acc_dat[ab+k], acc_we[ab+k], want_a[k], want_d[k]);
        end
      end
    end
  endtask

  task automatic test_read_sparse();
    int c0, tb, ab; bit to;
    set_script(0, 0, 0, 0, 0);
    scr_data[0] = 8'h11; scr_data[1] = 8'h22;
    do_xfer(32'h100, 32'h0, 4'b0101, 1'b0, c0, tb, ab, to);
    checks++;
    if (to || term_kind.size() - tb != 1 || term_kind[tb] != 0 || term_dat[tb] !== 32'h00110022) begin
      errors++; $display("FAIL rd_sparse_data: got %h (terms %0d) want 00110022",
                         (term_kind.size() > tb) ? term_dat[tb] : 32'hX, term_kind.size() - tb);
    end
    checks++;
    if (acc_adr.size() - ab != 2 || acc_adr[ab] !== 32'h101 || acc_adr[ab+1] !== 32'h103 || acc_we[ab] !== 1'b0) begin
      errors++; $display("FAIL rd_sparse_adr: got %0d accesses want 101,103 read", acc_adr.size() - ab);
    end
  endtask

  task automatic test_err_abort();
    int c0, tb, ab; bit to;
    set_script(0, 1, 0, 0, 0);
    do_xfer(32'h200, 32'h0, 4'b1111, 1'b0, c0, tb, ab, to);
    checks++;
    if (to || term_kind.size() - tb != 1 || term_kind[tb] != 1) begin
      errors++; $display("FAIL err_term: got %0d terms (first kind %0d) want one err",
                         term_kind.size() - tb, (term_kind.size() > tb) ? term_kind[tb] : -1);
    end else begin
      checks++;
      if (term_cyc[tb] - c0 != 3) begin errors++; $display("FAIL err_latency: got %0d want 3", term_cyc[tb] - c0); end
    end
    checks++;
    if (acc_adr.size() - ab != 2) begin errors++; $display("FAIL err_accesses: got %0d want 2", acc_adr.size() - ab); end
  endtask

  task automatic test_sel_zero();
    int c0, tb, ab, h0; bit to;
    set_script(0, 0, 0, 0, 0);
    h0 = cyc_hi;
    do_xfer(32'h300, 32'h12345678, 4'b0000, 1'b0, c0, tb, ab, to);
    checks++;
    if (to || term_kind.size() - tb != 1 || term_kind[tb] != 0 || term_cyc[tb] - c0 != 1 || term_dat[tb] !== 32'h0) begin
      errors++; $display("FAIL sel0_ack: got terms %0d timeout=%0d want one ack at +1 with data 0", term_kind.size() - tb, to);
    end
    checks++;
    if (cyc_hi != h0) begin errors++; $display("FAIL sel0_no_cyc: got %0d cyc cycles want 0", cyc_hi - h0); end
  endtask

  task automatic test_master_drop();
    int c0, tb, ab; bit to, seen;
    set_script(0, 0, 0, 0, 5);
    scr_wait[0] = 0;
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h400; wbm_sel_i = 4'b1111; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    tb = term_kind.size();
    ab = acc_adr.size();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i); #1;
      if (acc_adr.size() > ab) begin seen = 1'b1; break; end
    end
    @(posedge wb_clk_i); #1;
    checks++;
    if (!seen || wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL drop_pre_cyc: got %b seen=%0d want 1", wbs_cyc_o, seen); end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    #1;
    checks++;
    if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin
      errors++; $display("FAIL drop_same_cycle: got cyc=%b stb=%b want 0", wbs_cyc_o, wbs_stb_o);
    end
    repeat (4) @(posedge wb_clk_i);
    #1;
    checks++;
    if (term_kind.size() != tb || acc_adr.size() - ab != 1 || wbs_cyc_o !== 1'b0) begin
      errors++; $display("FAIL drop_quiet: got terms %0d accesses %0d want 0 and 1", term_kind.size() - tb, acc_adr.size() - ab);
    end
    set_script(0, 0, 0, 0, 0);
    do_xfer(32'h500, 32'h0, 4'b0000, 1'b0, c0, tb, ab, to);
    checks++;
    if (to || term_kind.size() - tb != 1 || term_cyc[tb] - c0 != 1 || acc_adr.size() != ab) begin
      errors++; $display("FAIL drop_back_idle: got terms %0d accesses %0d want fresh ack at +1", term_kind.size() - tb, acc_adr.size() - ab);
    end
  endtask

  task automatic test_reset_midxfer();
    set_script(3, 3, 3, 3, 0);
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h600; wbm_sel_i = 4'b1111; wbm_we_i = 1'b1; wbm_dat_i = 32'hDEADBEEF;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #3;
    checks++;
    if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h600) begin
      errors++; $display("FAIL rstmid_pre: got cyc=%b adr=%h want 1/600", wbs_cyc_o, wbs_adr_o);
    end
    wb_rst_ni = 1'b0;
    #1;
    checks++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o} !== 43'h0) begin
      errors++; $display("FAIL rstmid_async: got %h want 0", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o});
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    checks++;
    if (wbs_cyc_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: got cyc=%b ack=%b want 0", wbs_cyc_o, wbm_ack_o);
    end
  endtask

`ifdef WB_RESIZE_TIMEOUT_EN
  task automatic test_timeout();
    int c0, tb, ab; bit to;
    set_script(3, 3, 3, 3, 0);
    do_xfer(32'h700, 32'h0, 4'b1111, 1'b0, c0, tb, ab, to);
    checks++;
    if (to || term_kind.size() - tb != 1 || term_kind[tb] != 1 || term_cyc[tb] - c0 != 18) begin
      errors++; $display("FAIL timeout_err: got terms %0d at +%0d want one err at +18",
                         term_kind.size() - tb, (term_kind.size() > tb) ? term_cyc[tb] - c0 : -1);
    end
  endtask
`endif

  task automatic test_random();
    int c0, tb, ab, r; bit to;
    logic [AW-1:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;
    for (int t = 0; t < 40; t++) begin
      adr = $urandom; dat = $urandom; sel = 4'($urandom_range(0, 15)); we = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        r = $urandom_range(0, 19);
        scr_kind[k] = (r < 14) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : (r == 18) ? 4 : 5;
        scr_wait[k] = $urandom_range(0, 3);
        scr_data[k] = 8'($urandom);
      end
      model_xfer(adr, dat, sel);
      do_xfer(adr, dat, sel, we, c0, tb, ab, to);
      checks++;
      if (to || term_kind.size() - tb != 1) begin
        errors++; $display("FAIL rand_term_count[%0d]: got %0d timeout=%0d want 1", t, term_kind.size() - tb, to);
        continue;
      end
      checks++;
      if (term_kind[tb] != exp_kind || term_cyc[tb] - c0 != exp_lat) begin
        errors++; $display("FAIL rand_term[%0d]: got kind %0d at +%0d want kind %0d at +%0d",
                           t, term_kind[tb], term_cyc[tb] - c0, exp_kind, exp_lat);
      end
      if (exp_kind == 0) begin
        checks++;
        if (term_dat[tb] !== exp_rd) begin
          errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, term_dat[tb], exp_rd);
        end
      end
      checks++;
      if (acc_adr.size() - ab != exp_n) begin
        errors++; $display("FAIL rand_accesses[%0d]: got %0d want %0d", t, acc_adr.size() - ab, exp_n);
        continue;
      end
      for (int k = 0; k < exp_n; k++) begin
        checks++;
        if (acc_adr[ab+k] !== exp_adr[k] || acc_we[ab+k] !== we || (we && acc_dat[ab+k] !== exp_wdat[k])) begin
          errors++; $display("FAIL rand_access[%0d.%0d]: got %h/%h we=%b want %h/%h we=%b",
                             t, k, acc_adr[ab+k], acc_dat[ab+k], acc_we[ab+k], exp_adr[k], exp_wdat[k], we);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_read_sparse();
    test_err_abort();
    test_sel_zero();
    test_master_drop();
    test_reset_midxfer();
`ifdef WB_RESIZE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
